// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: feeds a 4-bit adder slice one nibble per cycle,
// LSB first, chaining the carry through a register.
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_s,
   input  logic             add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int N  = WIDTH / 4;
   localparam int SW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [SW-1:0]    step;
   logic             last;
   logic             carry_r;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_nx;

   assign last   = (step == SW'(N - 1));
   assign sum_nx = {add_s, sum_sh[WIDTH-1:4]};

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      add_a     = 4'h0;
      add_b     = 4'h0;
      add_cin   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            busy    = 1'b1;
            add_a   = a_sh[3:0];
            add_b   = b_sh[3:0];
            add_cin = carry_r;
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operand shifters, carry chain, step count and result capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         carry_r <= 1'b0;
         step    <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  carry_r <= cin;
                  step    <= '0;
               end
            end
            RUN: begin
               sum_sh  <= sum_nx;
               a_sh    <= {4'h0, a_sh[WIDTH-1:4]};
               b_sh    <= {4'h0, b_sh[WIDTH-1:4]};
               carry_r <= add_cout;
               step    <= step + 1'b1;
               if (last) begin
                  sum  <= sum_nx;
                  cout <= add_cout;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vectors against an arithmetic
// transaction model, plus literal checks on key results.
module tb_nibble_serial_adder;

   localparam int WIDTH = 16;
   localparam int N     = WIDTH / 4;

   logic             clk;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [3:0]       add_a;
   logic [3:0]       add_b;
   logic             add_cin;
   logic [3:0]       add_s;
   logic             add_cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   int tests;
   int fails;

   logic [3:0] nib_a [N];
   logic       nib_c [N];

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_s     (add_s),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   // Combinational 4-bit adder slice
   assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Transaction model: phase -1 idle, 0..N-1 nibble index, N done
   int               m_phase;
   logic [WIDTH-1:0] m_a;
   logic [WIDTH-1:0] m_b;
   logic             m_cin;
   logic [WIDTH-1:0] m_sum;
   logic             m_cout;

   function automatic logic carry_into(input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] y,
                                       input logic c, input int k);
      logic [63:0] mask;
      logic [63:0] t;
      mask = (64'd1 << (4 * k)) - 64'd1;
      t = (64'(x) & mask) + (64'(y) & mask) + 64'(c);
      return t[4*k];
   endfunction

   // Model advance on each clock edge
   always @(posedge clk or negedge reset_n) begin
      logic [WIDTH:0] t;
      if (!reset_n) begin
         m_phase <= -1;
         m_sum   <= '0;
         m_cout  <= 1'b0;
      end else if (m_phase == -1) begin
         if (in_valid) begin
            m_a     <= a;
            m_b     <= b;
            m_cin   <= cin;
            m_phase <= 0;
         end
      end else if (m_phase < N - 1) begin
         m_phase <= m_phase + 1;
      end else if (m_phase == N - 1) begin
         t = {1'b0, m_a} + {1'b0, m_b} + (WIDTH + 1)'(m_cin);
         m_sum   <= t[WIDTH-1:0];
         m_cout  <= t[WIDTH];
         m_phase <= N;
      end else if (out_ready) begin
         m_phase <= -1;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      logic [3:0] ea;
      logic [3:0] eb;
      logic       ec;
      if (reset_n === 1'b1) begin
         ea = 4'h0;
         eb = 4'h0;
         ec = 1'b0;
         if (m_phase >= 0 && m_phase < N) begin
            ea = 4'(m_a >> (4 * m_phase));
            eb = 4'(m_b >> (4 * m_phase));
            ec = carry_into(m_a, m_b, m_cin, m_phase);
         end
         chk("cyc in_ready", 32'(in_ready), 32'(m_phase == -1));
         chk("cyc out_valid", 32'(out_valid), 32'(m_phase == N));
         chk("cyc busy", 32'(busy), 32'(m_phase != -1));
         chk("cyc add_a", 32'(add_a), 32'(ea));
         chk("cyc add_b", 32'(add_b), 32'(eb));
         chk("cyc add_cin", 32'(add_cin), 32'(ec));
         chk("cyc sum", 32'(sum), 32'(m_sum));
         chk("cyc cout", 32'(cout), 32'(m_cout));
      end
   end

   // One operation; entered and left 1 time unit after a rising edge
   task automatic do_op(input logic [WIDTH-1:0] ta,
                        input logic [WIDTH-1:0] tb,
                        input logic tc,
                        input logic [WIDTH-1:0] es,
                        input logic ec,
                        input int hold);
      int w;
      a = ta;
      b = tb;
      cin = tc;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 20) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("accept wait", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         nib_a[k] = add_a;
         nib_c[k] = add_cin;
         chk("run no valid", 32'(out_valid), 32'd0);
         @(posedge clk);
         #1;
      end
      chk("latency valid", 32'(out_valid), 32'd1);
      chk("sum literal", 32'(sum), 32'(es));
      chk("cout literal", 32'(cout), 32'(ec));
      if (hold > 0) begin
         a = 16'hAAAA;
         b = 16'h1111;
         cin = 1'b0;
         in_valid = 1'b1;
         for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("bp valid", 32'(out_valid), 32'd1);
            chk("bp sum", 32'(sum), 32'(es));
            chk("bp in_ready", 32'(in_ready), 32'd0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("back idle", 32'(in_ready), 32'd1);
      chk("kept sum", 32'(sum), 32'(es));
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst sum", 32'(sum), 32'd0);
      chk("rst cout", 32'(cout), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst add", 32'({add_a, add_b, add_cin}), 32'd0);
      reset_n = 1'b1;
      #1;
      chk("rst in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0);
      chk("basic nib0", 32'(nib_a[0]), 32'd4);
      chk("basic nib1", 32'(nib_a[1]), 32'd3);
      chk("basic nib2", 32'(nib_a[2]), 32'd2);
      chk("basic nib3", 32'(nib_a[3]), 32'd1);

      do_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0);
      for (int k = 0; k < N; k++) begin
         chk("ripple cin", 32'(nib_c[k]), 32'd1);
      end

      do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 5);
      do_op(16'hAAAA, 16'h1111, 1'b0, 16'hBBBB, 1'b0, 0);

      a = 16'h00FF;
      b = 16'h0001;
      cin = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("mid busy", 32'(busy), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid rst valid", 32'(out_valid), 32'd0);
      chk("mid rst busy", 32'(busy), 32'd0);
      chk("mid rst add_a", 32'(add_a), 32'd0);
      chk("mid rst sum", 32'(sum), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("mid no valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
